// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and its issue scheduler:
// opcodes, scheduler states and default latencies.
package md_pkg;

    localparam logic [2:0] MD_MFHI  = 3'd0;
    localparam logic [2:0] MD_MFLO  = 3'd1;
    localparam logic [2:0] MD_MTHI  = 3'd2;
    localparam logic [2:0] MD_MTLO  = 3'd3;
    localparam logic [2:0] MD_MULT  = 3'd4;
    localparam logic [2:0] MD_MULTU = 3'd5;
    localparam logic [2:0] MD_DIV   = 3'd6;
    localparam logic [2:0] MD_DIVU  = 3'd7;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;
    localparam int MD_LAT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } md_state_e;

    // Opcodes 4..7 occupy the MDU datapath; 0..3 only touch HI/LO.
    function automatic logic is_mul_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Divides are opcodes 6 and 7.
    function automatic logic is_div(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// Request/issue bundle between the E stage, the scheduler and the MDU.
interface md_sched_if;

    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_d1;
    logic [31:0] req_d2;
    logic        req_ready;
    logic        stall;
    logic        flush;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_d1;
    logic [31:0] mdu_d2;
    logic        mdu_busy;

    modport master (
        output req_valid, req_op, req_d1, req_d2, flush, mdu_busy,
        input  req_ready, stall, mdu_start, mdu_op, mdu_d1, mdu_d2
    );

    modport slave (
        input  req_valid, req_op, req_d1, req_d2, flush, mdu_busy,
        output req_ready, stall, mdu_start, mdu_op, mdu_d1, mdu_d2
    );

endinterface

// File: rtl/md_lat_cnt.sv
// Loadable down-counter; done flags the last busy cycle (count of one).
module md_lat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/md_sched.sv
// Issue scheduler for the MDU: serialises MD ops, pulses start for mult/div
// and holds off every following MD op until HI/LO are final.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    md_sched_if.slave        bus,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    md_state_e        state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      d1_q, d1_d;
    logic [31:0]      d2_q, d2_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             req_ready_s;
    logic             stall_s;
    logic             start_s;
    logic [2:0]       mdu_op_s;
    logic [31:0]      mdu_d1_s;
    logic [31:0]      mdu_d2_s;
    logic             cnt_load_s;
    logic             cnt_en_s;
    logic             cnt_done_s;
    logic [MD_LAT_W-1:0] cnt_val_s;

    assign cnt_load_s = (state_q == ISSUE) & ~bus.flush;
    assign cnt_en_s   = (state_q == WAIT);
    assign cnt_val_s  = is_div(op_q) ? MD_LAT_W'(DIV_LAT) : MD_LAT_W'(MUL_LAT);

    md_lat_cnt #(
        .W (MD_LAT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .en_i       (cnt_en_s),
        .done_o     (cnt_done_s)
    );

    // Next-state, operand latch and MDU-facing outputs.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        req_ready_s = 1'b0;
        start_s     = 1'b0;
        mdu_op_s    = MD_MFHI;
        mdu_d1_s    = 32'd0;
        mdu_d2_s    = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready_s = 1'b1;
                if (bus.req_valid) begin
                    if (is_mul_div(bus.req_op)) begin
                        op_d    = bus.req_op;
                        d1_d    = bus.req_d1;
                        d2_d    = bus.req_d2;
                        state_d = ISSUE;
                    end else begin
                        mdu_op_s = bus.req_op;
                        mdu_d1_s = bus.req_d1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                mdu_op_s = op_q;
                mdu_d1_s = d1_q;
                mdu_d2_s = d2_q;
                // A flushed op never reaches the MDU.
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    start_s = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_s = bus.req_valid & ~req_ready_s;

    // Sticky consistency error and saturating stall counter.
    always_comb begin
        err_d       = err_q | ((state_q == IDLE) & bus.mdu_busy);
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            d1_q        <= 32'd0;
            d2_q        <= 32'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.stall     = stall_s;
    assign bus.mdu_start = start_s;
    assign bus.mdu_op    = mdu_op_s;
    assign bus.mdu_d1    = mdu_d1_s;
    assign bus.mdu_d2    = mdu_d2_s;
    assign err           = err_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched; a second instance with a 2-bit stall counter
// shares the same stimulus to exercise saturation.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        err;
    logic [15:0] stall_cnt;
    logic        err2;
    logic [1:0]  stall_cnt2;
    int          checks;
    int          errors;

    md_sched_if bus ();
    md_sched_if bus2 ();

    assign bus2.req_valid = bus.req_valid;
    assign bus2.req_op    = bus.req_op;
    assign bus2.req_d1    = bus.req_d1;
    assign bus2.req_d2    = bus.req_d2;
    assign bus2.flush     = bus.flush;
    assign bus2.mdu_busy  = bus.mdu_busy;

    md_sched #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .err(err), .stall_cnt(stall_cnt)
    );

    md_sched #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .err(err2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_d1    = a;
        bus.req_d2    = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        bus.flush = 1'b0;
        bus.mdu_busy = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (bus.mdu_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.mdu_start); end
        checks++; if ({bus.mdu_op, bus.mdu_d1, bus.mdu_d2} !== 67'd0) begin errors++; $display("FAIL reset_mdu_bus: got %h/%h/%h want 0", bus.mdu_op, bus.mdu_d1, bus.mdu_d2); end
        checks++; if (err !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %b/%0d want 0/0", err, stall_cnt); end
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_mult_mflo();
        drive(1'b1, 3'd4, 32'd3, 32'hFFFF_FFFE);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.mdu_start !== 1'b0) begin errors++; $display("FAIL mult_accept: got ready=%b start=%b want 1/0", bus.req_ready, bus.mdu_start); end
        next_cycle();
        drive(1'b1, 3'd1, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 3'd4) begin errors++; $display("FAIL mult_start: got start=%b op=%0d want 1/4", bus.mdu_start, bus.mdu_op); end
        checks++; if (bus.mdu_d1 !== 32'd3 || bus.mdu_d2 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_operands: got %h/%h want 00000003/fffffffe", bus.mdu_d1, bus.mdu_d2); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mult_stall_c1: got %b want 1", bus.stall); end
        next_cycle();
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            checks++; if (bus.mdu_start !== 1'b0 || bus.stall !== 1'b1 || bus.mdu_op !== 3'd0) begin errors++; $display("FAIL mult_wait_c%0d: got start=%b stall=%b op=%0d want 0/1/0", c, bus.mdu_start, bus.stall, bus.mdu_op); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0 || bus.mdu_op !== 3'd1) begin errors++; $display("FAIL mflo_accept_c7: got ready=%b stall=%b op=%0d want 1/0/1", bus.req_ready, bus.stall, bus.mdu_op); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL mult_stall_cnt: got %0d want 6", stall_cnt); end
        checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt_after_mult: got %0d want 3", stall_cnt2); end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        next_cycle();
    endtask

    task automatic test_divu_mfhi();
        drive(1'b1, 3'd7, 32'd100, 32'd7);
        next_cycle();
        drive(1'b1, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 3'd7 || bus.mdu_d1 !== 32'd100 || bus.mdu_d2 !== 32'd7) begin errors++; $display("FAIL divu_start: got start=%b op=%0d d1=%0d d2=%0d want 1/7/100/7", bus.mdu_start, bus.mdu_op, bus.mdu_d1, bus.mdu_d2); end
        next_cycle();
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 1'b0 || bus.stall !== 1'b1 || bus.mdu_start !== 1'b0) begin errors++; $display("FAIL divu_wait_c%0d: got ready=%b stall=%b start=%b want 0/1/0", c, bus.req_ready, bus.stall, bus.mdu_start); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL mfhi_accept_c12: got ready=%b stall=%b want 1/0", bus.req_ready, bus.stall); end
        checks++; if (stall_cnt !== 16'd17) begin errors++; $display("FAIL divu_stall_cnt: got %0d want 17", stall_cnt); end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        next_cycle();
    endtask

    task automatic test_flush();
        drive(1'b1, 3'd6, 32'd5, 32'd6);
        next_cycle();
        drive(1'b1, 3'd5, 32'd9, 32'd2);
        bus.flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.mdu_start !== 1'b0 || bus.stall !== 1'b1 || bus.mdu_op !== 3'd6) begin errors++; $display("FAIL flush_c1: got start=%b stall=%b op=%0d want 0/1/6", bus.mdu_start, bus.stall, bus.mdu_op); end
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.mdu_start !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL flush_idle_c2: got ready=%b start=%b stall=%b want 1/0/0", bus.req_ready, bus.mdu_start, bus.stall); end
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 3'd5 || bus.mdu_d1 !== 32'd9 || bus.mdu_d2 !== 32'd2) begin errors++; $display("FAIL flush_retry_start: got start=%b op=%0d d1=%0d d2=%0d want 1/5/9/2", bus.mdu_start, bus.mdu_op, bus.mdu_d1, bus.mdu_d2); end
        for (int c = 4; c <= 9; c++) next_cycle();
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || stall_cnt !== 16'd18) begin errors++; $display("FAIL flush_end: got ready=%b cnt=%0d want 1/18", bus.req_ready, stall_cnt); end
    endtask

    task automatic test_mt();
        drive(1'b1, 3'd2, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        checks++; if (bus.mdu_op !== 3'd2 || bus.mdu_d1 !== 32'hDEAD_BEEF || bus.mdu_d2 !== 32'd0) begin errors++; $display("FAIL mthi_pass: got op=%0d d1=%h d2=%h want 2/deadbeef/0", bus.mdu_op, bus.mdu_d1, bus.mdu_d2); end
        checks++; if (bus.req_ready !== 1'b1 || bus.mdu_start !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_hs: got ready=%b start=%b stall=%b want 1/0/0", bus.req_ready, bus.mdu_start, bus.stall); end
        next_cycle();
        drive(1'b1, 3'd3, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        checks++; if (bus.mdu_op !== 3'd3 || bus.mdu_d1 !== 32'hCAFE_F00D || bus.req_ready !== 1'b1) begin errors++; $display("FAIL mtlo_pass: got op=%0d d1=%h ready=%b want 3/cafef00d/1", bus.mdu_op, bus.mdu_d1, bus.req_ready); end
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.mdu_start !== 1'b0 || bus.mdu_op !== 3'd0 || bus.mdu_d1 !== 32'd0) begin errors++; $display("FAIL mt_idle: got ready=%b start=%b op=%0d d1=%h want 1/0/0/0", bus.req_ready, bus.mdu_start, bus.mdu_op, bus.mdu_d1); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd4, 32'd7, 32'd8);
        next_cycle();
        drive(1'b1, 3'd6, 32'd20, 32'd4);
        @(negedge clk);
        checks++; if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 3'd4 || bus.mdu_d1 !== 32'd7) begin errors++; $display("FAIL b2b_first_start: got start=%b op=%0d d1=%0d want 1/4/7", bus.mdu_start, bus.mdu_op, bus.mdu_d1); end
        for (int c = 2; c <= 7; c++) next_cycle();
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0 || bus.mdu_start !== 1'b0) begin errors++; $display("FAIL b2b_accept_c7: got ready=%b stall=%b start=%b want 1/0/0", bus.req_ready, bus.stall, bus.mdu_start); end
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 3'd6 || bus.mdu_d1 !== 32'd20 || bus.mdu_d2 !== 32'd4) begin errors++; $display("FAIL b2b_second_start: got start=%b op=%0d d1=%0d d2=%0d want 1/6/20/4", bus.mdu_start, bus.mdu_op, bus.mdu_d1, bus.mdu_d2); end
        next_cycle();
        for (int c = 9; c <= 18; c++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 1'b0 || bus.mdu_start !== 1'b0) begin errors++; $display("FAIL b2b_wait_c%0d: got ready=%b start=%b want 0/0", c, bus.req_ready, bus.mdu_start); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || stall_cnt !== 16'd24) begin errors++; $display("FAIL b2b_end: got ready=%b cnt=%0d want 1/24", bus.req_ready, stall_cnt); end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b1, 3'd4, 32'd11, 32'd12);
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        for (int c = 1; c <= 3; c++) next_cycle();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_wait: got ready=%b want 0", bus.req_ready); end
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.mdu_start !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL rst_async_hs: got ready=%b start=%b stall=%b want 1/0/0", bus.req_ready, bus.mdu_start, bus.stall); end
        checks++; if (bus.mdu_op !== 3'd0 || bus.mdu_d1 !== 32'd0 || stall_cnt !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL rst_async_state: got op=%0d d1=%h cnt=%0d err=%b want 0/0/0/0", bus.mdu_op, bus.mdu_d1, stall_cnt, err); end
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        drive(1'b1, 3'd1, 32'h55, 32'd0);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.mdu_op !== 3'd1 || bus.stall !== 1'b0) begin errors++; $display("FAIL rst_release_idle: got ready=%b op=%0d stall=%b want 1/1/0", bus.req_ready, bus.mdu_op, bus.stall); end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        next_cycle();
    endtask

    task automatic test_err();
        bus.mdu_busy = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_same_cycle: got %b want 0", err); end
        next_cycle();
        bus.mdu_busy = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
        next_cycle();
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        next_cycle();
    endtask

    task automatic test_saturate();
        drive(1'b1, 3'd4, 32'd1, 32'd2);
        next_cycle();
        drive(1'b1, 3'd1, 32'd0, 32'd0);
        for (int c = 1; c <= 5; c++) next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2: got %0d want 3", stall_cnt2); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16: got %0d want 5", stall_cnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL sat_idle: got %b want 1", bus.req_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult_mflo();
        test_divu_mfhi();
        test_flush();
        test_mt();
        test_back_to_back();
        test_reset_mid_wait();
        test_err();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
